// File: rtl/issue_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : issue_scoreboard_if
// Brief    : Decode-to-issue handshake bundle carrying one decoded instruction.
// Revision : 1.0
// ============================================================================
interface issue_scoreboard_if #(
    parameter int NREG = 16
);
    localparam int IDX_W = $clog2(NREG);

    logic             dec_valid;
    logic             dec_ready;
    logic [IDX_W-1:0] src1_idx;
    logic [IDX_W-1:0] src2_idx;
    logic             src1_type;
    logic             src2_type;
    logic             src1_used;
    logic             src2_used;
    logic [IDX_W-1:0] dest_idx;
    logic             dest_type;
    logic             dest_used;
    logic             vec_op;

    modport master (
        output dec_valid, src1_idx, src2_idx, src1_type, src2_type,
               src1_used, src2_used, dest_idx, dest_type, dest_used, vec_op,
        input  dec_ready
    );

    modport slave (
        input  dec_valid, src1_idx, src2_idx, src1_type, src2_type,
               src1_used, src2_used, dest_idx, dest_type, dest_used, vec_op,
        output dec_ready
    );
endinterface
`default_nettype wire

// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : issue_scoreboard
// Brief    : Busy-bit scoreboard issue gate for scalar/vector register files.
// Revision : 1.0
// ============================================================================
module issue_scoreboard #(
    parameter int NREG       = 16,
    parameter int VEC_CYCLES = 4
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    issue_scoreboard_if.slave            dec,
    input  wire logic                    wb_valid,
    input  wire logic [$clog2(NREG)-1:0] wb_idx,
    input  wire logic                    wb_type,
    input  wire logic                    flush,
    output logic                         issue,
    output logic                         stall,
    output logic                         exec_busy,
    output logic [NREG-1:0]              busy_s,
    output logic [NREG-1:0]              busy_v,
    output logic                         wb_err
);
    localparam int OCC_W = (VEC_CYCLES > 1) ? $clog2(VEC_CYCLES) : 1;
    localparam logic [OCC_W-1:0] c_occ_load = OCC_W'(VEC_CYCLES - 1);

    logic [NREG-1:0]  r_busy_s;
    logic [NREG-1:0]  r_busy_v;
    logic [OCC_W-1:0] r_occ;
    logic             r_wb_err;

    logic [NREG-1:0]  w_wb_onehot;
    logic [NREG-1:0]  w_dest_onehot;
    logic [NREG-1:0]  w_clr_s, w_clr_v;
    logic [NREG-1:0]  w_set_s, w_set_v;
    logic [NREG-1:0]  w_eff_s, w_eff_v;
    logic             w_src1_busy, w_src2_busy, w_dest_busy;
    logic             w_hazard, w_issue, w_wb_hit;

    // A write-back landing this cycle already frees its register for hazard checks.
    assign w_wb_onehot   = NREG'(1) << wb_idx;
    assign w_dest_onehot = NREG'(1) << dec.dest_idx;
    assign w_clr_s       = (wb_valid & ~wb_type) ? w_wb_onehot : '0;
    assign w_clr_v       = (wb_valid &  wb_type) ? w_wb_onehot : '0;
    assign w_eff_s       = r_busy_s & ~w_clr_s;
    assign w_eff_v       = r_busy_v & ~w_clr_v;

    assign w_src1_busy = dec.src1_used &
                         (dec.src1_type ? w_eff_v[dec.src1_idx] : w_eff_s[dec.src1_idx]);
    assign w_src2_busy = dec.src2_used &
                         (dec.src2_type ? w_eff_v[dec.src2_idx] : w_eff_s[dec.src2_idx]);
    assign w_dest_busy = dec.dest_used &
                         (dec.dest_type ? w_eff_v[dec.dest_idx] : w_eff_s[dec.dest_idx]);

    assign w_hazard      = w_src1_busy | w_src2_busy | w_dest_busy | (r_occ != '0) | flush;
    assign dec.dec_ready = ~rst & ~w_hazard;
    assign w_issue       = dec.dec_valid & dec.dec_ready;

    assign w_set_s  = (w_issue & dec.dest_used & ~dec.dest_type) ? w_dest_onehot : '0;
    assign w_set_v  = (w_issue & dec.dest_used &  dec.dest_type) ? w_dest_onehot : '0;
    assign w_wb_hit = wb_type ? r_busy_v[wb_idx] : r_busy_s[wb_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_s <= '0;
            r_busy_v <= '0;
            r_occ    <= '0;
            r_wb_err <= 1'b0;
        end else begin
            if (flush) begin
                r_busy_s <= '0;
                r_busy_v <= '0;
                r_occ    <= '0;
            end else begin
                // Set after clear so a same-cycle reissue keeps the bit busy.
                r_busy_s <= (r_busy_s & ~w_clr_s) | w_set_s;
                r_busy_v <= (r_busy_v & ~w_clr_v) | w_set_v;
                if (w_issue & dec.vec_op)
                    r_occ <= c_occ_load;
                else if (r_occ != '0)
                    r_occ <= r_occ - 1'b1;
            end
            if (wb_valid & ~w_wb_hit)
                r_wb_err <= 1'b1;
        end
    end

    assign issue     = w_issue;
    assign stall     = dec.dec_valid & ~dec.dec_ready & ~rst;
    assign exec_busy = (r_occ != '0);
    assign busy_s    = r_busy_s;
    assign busy_v    = r_busy_v;
    assign wb_err    = r_wb_err;
endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_scoreboard
// Brief    : Directed vector table plus reset/aliasing sequences for issue_scoreboard.
// Revision : 1.0
// ============================================================================
module tb_issue_scoreboard;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_valid, wb_type, flush;
    logic [3:0]  wb_idx;
    logic        issue, stall, exec_busy, wb_err;
    logic [15:0] busy_s, busy_v;
    int          checks = 0;
    int          failures = 0;

    issue_scoreboard_if #(.NREG(16)) dif ();

    issue_scoreboard #(.NREG(16), .VEC_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .dec(dif.slave),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_type(wb_type), .flush(flush),
        .issue(issue), .stall(stall), .exec_busy(exec_busy),
        .busy_s(busy_s), .busy_v(busy_v), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    // flags = {issue, stall, dec_ready, exec_busy, wb_err}
    typedef struct {
        logic       dv;
        logic       s1u, s1t; logic [3:0] s1;
        logic       s2u, s2t; logic [3:0] s2;
        logic       du, dt;   logic [3:0] d;
        logic       vop;
        logic       wbv, wbt; logic [3:0] wbi;
        logic       fl;
        logic [4:0] e_flags;
        logic [15:0] e_bs, e_bv;
    } vec_t;

    vec_t tbl [19];

    task automatic drive(input vec_t v);
        dif.dec_valid = v.dv;
        dif.src1_used = v.s1u; dif.src1_type = v.s1t; dif.src1_idx = v.s1;
        dif.src2_used = v.s2u; dif.src2_type = v.s2t; dif.src2_idx = v.s2;
        dif.dest_used = v.du;  dif.dest_type = v.dt;  dif.dest_idx = v.d;
        dif.vec_op = v.vop;
        wb_valid = v.wbv; wb_type = v.wbt; wb_idx = v.wbi;
        flush = v.fl;
    endtask

    task automatic check(input string name, input logic [4:0] ef,
                         input logic [15:0] ebs, input logic [15:0] ebv);
        logic [36:0] act, exp;
        act = {issue, stall, dif.dec_ready, exec_busy, wb_err, busy_s, busy_v};
        exp = {ef, ebs, ebv};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got flags=%b busy_s=%h busy_v=%h, want flags=%b busy_s=%h busy_v=%h",
                     name, act[36:32], act[31:16], act[15:0], ef, ebs, ebv);
        end
    endtask

    vec_t idle, v;

    initial begin
        idle = '{0, 0,0,4'd0, 0,0,4'd0, 0,0,4'd0, 0, 0,0,4'd0, 0, 5'b0, 16'h0, 16'h0};
        tbl[0]  = '{1, 0,0,4'd0, 0,0,4'd0, 1,0,4'd4, 0, 0,0,4'd0, 0, 5'b10100, 16'h0000, 16'h0000};
        tbl[1]  = '{1, 1,0,4'd4, 1,0,4'd2, 1,0,4'd5, 0, 0,0,4'd0, 0, 5'b01000, 16'h0010, 16'h0000};
        tbl[2]  = tbl[1];
        tbl[3]  = '{1, 1,0,4'd4, 1,0,4'd2, 1,0,4'd5, 0, 1,0,4'd4, 0, 5'b10100, 16'h0010, 16'h0000};
        tbl[4]  = '{1, 0,0,4'd0, 0,0,4'd0, 1,1,4'd1, 1, 0,0,4'd0, 0, 5'b10100, 16'h0020, 16'h0000};
        tbl[5]  = '{1, 1,0,4'd0, 0,0,4'd0, 1,0,4'd6, 0, 0,0,4'd0, 0, 5'b01010, 16'h0020, 16'h0002};
        tbl[6]  = tbl[5];
        tbl[7]  = tbl[5];
        tbl[8]  = '{1, 1,0,4'd0, 0,0,4'd0, 1,0,4'd6, 0, 0,0,4'd0, 0, 5'b10100, 16'h0020, 16'h0002};
        tbl[9]  = '{1, 0,0,4'd0, 0,0,4'd0, 1,0,4'd7, 0, 0,0,4'd0, 0, 5'b10100, 16'h0060, 16'h0002};
        tbl[10] = '{1, 0,0,4'd0, 0,0,4'd0, 1,0,4'd7, 0, 1,0,4'd7, 0, 5'b10100, 16'h00E0, 16'h0002};
        tbl[11] = '{0, 0,0,4'd0, 0,0,4'd0, 0,0,4'd0, 0, 1,1,4'd9, 0, 5'b00100, 16'h00E0, 16'h0002};
        tbl[12] = '{1, 0,0,4'd0, 0,0,4'd0, 1,0,4'd4, 1, 0,0,4'd0, 0, 5'b10101, 16'h00E0, 16'h0002};
        tbl[13] = '{0, 0,0,4'd0, 0,0,4'd0, 0,0,4'd0, 0, 0,0,4'd0, 0, 5'b00011, 16'h00F0, 16'h0002};
        tbl[14] = '{1, 1,0,4'd4, 0,0,4'd0, 1,0,4'd8, 0, 0,0,4'd0, 1, 5'b01011, 16'h00F0, 16'h0002};
        tbl[15] = '{1, 1,0,4'd4, 0,0,4'd0, 1,0,4'd8, 0, 0,0,4'd0, 0, 5'b10101, 16'h0000, 16'h0000};
        tbl[16] = '{1, 0,0,4'd0, 0,0,4'd0, 1,1,4'd0, 0, 0,0,4'd0, 0, 5'b10101, 16'h0100, 16'h0000};
        tbl[17] = '{1, 0,0,4'd0, 0,0,4'd0, 1,1,4'd1, 0, 0,0,4'd0, 0, 5'b10101, 16'h0100, 16'h0001};
        tbl[18] = '{0, 0,0,4'd0, 0,0,4'd0, 0,0,4'd0, 0, 0,0,4'd0, 0, 5'b00101, 16'h0100, 16'h0003};

        // Reset held with a valid instruction waiting: nothing may issue.
        drive(tbl[0]);
        #2 check("reset_state", 5'b00000, 16'h0000, 16'h0000);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            if (i == 0) rst = 1'b0;
            drive(tbl[i]);
            #1 check($sformatf("vec%0d", i), tbl[i].e_flags, tbl[i].e_bs, tbl[i].e_bv);
        end

        // Asynchronous reset between edges with V0/V1 in flight.
        @(negedge clk);
        v = idle; v.dv = 1'b1; v.du = 1'b1; v.dt = 1'b1; v.d = 4'd2;
        drive(v);
        #1 check("pre_rst", 5'b10101, 16'h0100, 16'h0003);
        #1 rst = 1'b1;
        #1 check("async_rst", 5'b00000, 16'h0000, 16'h0000);

        // Write-back of a register lost by reset flags an error.
        @(negedge clk);
        rst = 1'b0;
        v = idle; v.wbv = 1'b1; v.wbi = 4'd5;
        drive(v);
        #1 check("stale_wb", 5'b00100, 16'h0000, 16'h0000);

        @(negedge clk);
        v = idle; v.dv = 1'b1; v.du = 1'b1; v.d = 4'd1;
        drive(v);
        #1 check("issue_S1", 5'b10101, 16'h0000, 16'h0000);

        // V1 must not alias S1.
        @(negedge clk);
        v = idle; v.dv = 1'b1; v.du = 1'b1; v.dt = 1'b1; v.d = 4'd1;
        drive(v);
        #1 check("issue_V1_no_alias", 5'b10101, 16'h0002, 16'h0000);

        @(negedge clk);
        v = idle; v.dv = 1'b1; v.s1u = 1'b1; v.s1 = 4'd1; v.du = 1'b1; v.dt = 1'b1; v.d = 4'd5;
        drive(v);
        #1 check("raw_S1", 5'b01001, 16'h0002, 16'h0002);

        @(negedge clk);
        drive(idle);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/issue_scoreboard.md
# issue_scoreboard

Issue controller between the decode stage and the execute stage of the vector processor. It tracks in-flight destination registers for the 16 scalar and 16 vector registers in a busy-bit scoreboard. It holds a decoded instruction until its sources and destination are free and the execute unit is not occupied by a multi-cycle vector operation. It then issues the instruction with a valid/ready handshake; write-back clears the scoreboard entries.

## Interface
- NREG, 16, registers per file (scalar and vector each); index width log2(NREG)=4
- VEC_CYCLES, 4, execute-unit occupancy in cycles of one vector op (min 1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous and active-high
- dec_valid  in  1  decode holds a valid instruction
- dec_ready  out  1  instruction accepted this cycle
- src1_idx / src2_idx  in  4  source register indices
- src1_type / src2_type  in  1  0 = scalar file, 1 = vector file
- src1_used / src2_used  in  1  source actually read
- dest_idx  in  4  destination index
- dest_type  in  1  0 = scalar, 1 = vector
- dest_used  in  1  instruction writes a register
- vec_op  in  1  instruction occupies execute for VEC_CYCLES cycles
- wb_valid  in  1  write-back completing this cycle
- wb_idx  in  4  write-back register index
- wb_type  in  1  write-back register file
- flush  in  1  synchronous pipeline flush
- issue  out  1  = dec_valid & dec_ready
- stall  out  1  = dec_valid & ~dec_ready
- exec_busy  out  1  execute occupied by a vector op
- busy_s  out  16  scalar scoreboard bits
- busy_v  out  16  vector scoreboard bits
- wb_err  out  1  sticky: write-back to a non-busy register

## Operation
- State: busy_s[15:0], busy_v[15:0], occupancy counter occ (width covers VEC_CYCLES-1), and sticky wb_err.
- Effective busy: eff = busy & ~wb_clear. wb_clear is the one-hot of wb_idx in the wb_type file when wb_valid=1. A write-back in the same cycle therefore resolves a hazard in that cycle.
- A hazard exists on any of these conditions:
  - a used source has its eff bit set (RAW);
  - dest_used=1 and the eff bit of dest is set (WAW);
  - occ != 0 (structural);
  - flush=1.
- dec_ready = ~rst & ~hazard. dec_ready is independent of dec_valid.
- On issue:
  - the busy bit of dest is set when dest_used=1;
  - when vec_op=1, occ loads VEC_CYCLES-1.
- occ decrements by 1 each cycle while nonzero. exec_busy = (occ != 0).
- Write-back clears the addressed bit. If issue sets the same bit in the same cycle, the set wins and the bit ends at 1.
- wb_valid to a register whose bit is 0 leaves state unchanged and sets wb_err. wb_err clears only on rst.
- flush clears all busy bits and occ at the next edge. It overrides issue and write-back in that cycle. wb_err is not affected.
- Scalar and vector files are independent: S3 and V3 are distinct entries.

## Timing
- Reset (async, immediate): busy_s=0, busy_v=0, occ=0, exec_busy=0, wb_err=0. dec_ready, issue and stall are 0 while rst=1.
- dec_ready, issue and stall are combinational from the inputs and current state, giving zero-cycle issue latency.
- busy bits, occ and wb_err update on the rising edge after the event and are visible in the next cycle.
- Vector op issued at edge N: dec_ready is 0 for cycles N+1 through N+VEC_CYCLES-1. The next instruction can issue in cycle N+VEC_CYCLES. With VEC_CYCLES=1 there is no structural stall.
- The decode stage must hold its instruction stable while stall=1.
- rst deasserted mid-operation: all in-flight state is lost. Write-backs that arrive afterwards set wb_err.

## Test plan
- Reset release with dec_valid=1 (MOV S4, imm: dest 4/scalar, no sources) -> issue=1 in the first cycle; busy_s=0x0010 next cycle.
- Then MULT S5 <- S4,S2 with no write-back -> stall=1 for every cycle. Drive wb_valid, idx 4, scalar -> issue=1 in the same cycle; the next cycle shows busy_s=0x0020.
- Vector op V1 issued with VEC_CYCLES=4, followed by an independent scalar op -> stall for exactly 3 cycles, issue on the 4th; exec_busy=1 for those 3 cycles.
- Issue dest S7 while wb_valid clears S7 in the same cycle -> busy_s[7]=1 afterwards and wb_err=0. Write-back to V9 while busy_v=0 -> wb_err=1, which stays set until rst.
- busy_s=0x00F0 and occ=2, then flush pulse coinciding with dec_valid -> issue=0 that cycle; next cycle busy_s=0, exec_busy=0, and the pending instruction issues.
- Assert rst asynchronously between edges while busy_v=0x0003 -> busy_v=0 and dec_ready=0 immediately; dest V1 and source S1 with bit 1 set in busy_s do not alias.
